// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator for a registered ALU. Takes one command at a time on a valid/ready
// request channel, drives the ALU operand/opcode inputs from registers, waits
// out the ALU pipeline latency, captures result and flags and offers them on a
// valid/ready response channel. Also keeps an accumulator for chained
// commands, sticky carry/overflow flags and a wrapping operation counter.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     request handshake
//   cmd_opcode/a/b      ALU command; cmd_a ignored when cmd_chain=1
//   cmd_chain           use the accumulator as operand A
//   cmd_clr_sticky      clear sticky flags before this command's flags land
//   alu_a/b/opcode      registered ALU inputs, stable from acceptance until
//                       the next acceptance
//   alu_result/flags    ALU outputs, sampled ALU_LATENCY edges after launch
//   rsp_valid/ready     response handshake
//   rsp_result/flags    captured result and {carryout, overflow, zero}
//   rsp_opcode          echo of the accepted opcode
//   acc                 last captured result
//   sticky_carry/ovf    OR of flags since last clear
//   op_count            completed operations, wraps silently
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int NUMBITS     = 16,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_opcode,
    input  logic [NUMBITS-1:0]  cmd_a,
    input  logic [NUMBITS-1:0]  cmd_b,
    input  logic                cmd_chain,
    input  logic                cmd_clr_sticky,
    output logic [NUMBITS-1:0]  alu_a,
    output logic [NUMBITS-1:0]  alu_b,
    output logic [2:0]          alu_opcode,
    input  logic [NUMBITS-1:0]  alu_result,
    input  logic                alu_carryout,
    input  logic                alu_overflow,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NUMBITS-1:0]  rsp_result,
    output logic [2:0]          rsp_flags,
    output logic [2:0]          rsp_opcode,
    output logic [NUMBITS-1:0]  acc,
    output logic                sticky_carry,
    output logic                sticky_overflow,
    output logic [CNT_BITS-1:0] op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Latency is at most 15, so a 4-bit wait counter always reaches it.
    localparam logic [3:0]          LAT_C   = 4'(ALU_LATENCY);
    localparam logic [3:0]          WC_ONE  = 4'd1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [1:0]          state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [NUMBITS-1:0]  alu_a_q, alu_a_d;
    logic [NUMBITS-1:0]  alu_b_q, alu_b_d;
    logic [2:0]          alu_opcode_q, alu_opcode_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NUMBITS-1:0]  rsp_result_q, rsp_result_d;
    logic [2:0]          rsp_flags_q, rsp_flags_d;
    logic [2:0]          rsp_opcode_q, rsp_opcode_d;
    logic [NUMBITS-1:0]  acc_q, acc_d;
    logic                sticky_carry_q, sticky_carry_d;
    logic                sticky_overflow_q, sticky_overflow_d;
    logic [CNT_BITS-1:0] op_count_q, op_count_d;

    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        alu_a_d           = alu_a_q;
        alu_b_d           = alu_b_q;
        alu_opcode_d      = alu_opcode_q;
        rsp_valid_d       = rsp_valid_q;
        rsp_result_d      = rsp_result_q;
        rsp_flags_d       = rsp_flags_q;
        rsp_opcode_d      = rsp_opcode_q;
        acc_d             = acc_q;
        sticky_carry_d    = sticky_carry_q;
        sticky_overflow_d = sticky_overflow_q;
        op_count_d        = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    // acc_q here is the previous response's result.
                    alu_a_d      = cmd_chain ? acc_q : cmd_a;
                    alu_b_d      = cmd_b;
                    alu_opcode_d = cmd_opcode;
                    rsp_opcode_d = cmd_opcode;
                    // Cleared now so this command's own flags still OR in.
                    if (cmd_clr_sticky) begin
                        sticky_carry_d    = 1'b0;
                        sticky_overflow_d = 1'b0;
                    end
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WC_ONE;
                // The ALU sampled our registers on the first WAIT edge, so
                // its output is valid once the counter reaches the latency.
                if (wait_cnt_q == LAT_C) begin
                    rsp_result_d      = alu_result;
                    rsp_flags_d       = {alu_carryout, alu_overflow, alu_zero};
                    acc_d             = alu_result;
                    sticky_carry_d    = sticky_carry_q | alu_carryout;
                    sticky_overflow_d = sticky_overflow_q | alu_overflow;
                    op_count_d        = op_count_q + CNT_ONE;
                    rsp_valid_d       = 1'b1;
                    state_d           = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            wait_cnt_q        <= '0;
            alu_a_q           <= '0;
            alu_b_q           <= '0;
            alu_opcode_q      <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_result_q      <= '0;
            rsp_flags_q       <= '0;
            rsp_opcode_q      <= '0;
            acc_q             <= '0;
            sticky_carry_q    <= 1'b0;
            sticky_overflow_q <= 1'b0;
            op_count_q        <= '0;
        end else begin
            state_q           <= state_d;
            wait_cnt_q        <= wait_cnt_d;
            alu_a_q           <= alu_a_d;
            alu_b_q           <= alu_b_d;
            alu_opcode_q      <= alu_opcode_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_result_q      <= rsp_result_d;
            rsp_flags_q       <= rsp_flags_d;
            rsp_opcode_q      <= rsp_opcode_d;
            acc_q             <= acc_d;
            sticky_carry_q    <= sticky_carry_d;
            sticky_overflow_q <= sticky_overflow_d;
            op_count_q        <= op_count_d;
        end
    end

    // IDLE is the only state that accepts, so ready and rsp_valid never overlap.
    assign cmd_ready       = (state_q == S_IDLE);
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_opcode      = alu_opcode_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_flags       = rsp_flags_q;
    assign rsp_opcode      = rsp_opcode_q;
    assign acc             = acc_q;
    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;
    assign op_count        = op_count_q;

endmodule
